// File: rtl/data_mem_responder_if.sv
// Pipeline-to-data-memory bus: M-stage load/store request, load data, stall and flush handshake.
// The pipeline side uses the master modport and the memory responder uses the slave modport.
interface data_mem_responder_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemStall;
  logic        FlushReq;
  logic        FlushDone;

  modport master (
    output MemWrite, MemRead, ALUResult, WriteData, FlushReq,
    input  ReadData, MemStall, FlushDone
  );

  modport slave (
    input  MemWrite, MemRead, ALUResult, WriteData, FlushReq,
    output ReadData, MemStall, FlushDone
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data RAM fronted by a FIFO store buffer with youngest-match load forwarding and an on-demand drain.
// Stores retire into RAM when no load needs the RAM read port, or when the buffer is full or draining.
module data_mem_responder #(
  parameter int MEM_WORDS = 64,
  parameter int SB_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_responder_if.slave mem_if
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int SW = $clog2(SB_DEPTH);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   head_q, head_d;
  logic [SW-1:0]   tail_q, tail_d;
  logic [AW-1:0]   sb_idx_q  [SB_DEPTH];
  logic [31:0]     sb_data_q [SB_DEPTH];
  logic [31:0]     mem_q     [MEM_WORDS];

  logic [AW-1:0]   req_idx_s;
  logic            full_s;
  logic            drain_s;
  logic            stall_s;
  logic            accept_s;
  logic            retire_s;
  logic            rd_en_s;
  logic            fwd_hit_s;
  logic [31:0]     fwd_data_s;
  logic [31:0]     rdata_s;
  logic            unused_addr_s;

  assign req_idx_s     = mem_if.ALUResult[AW+1:2];
  assign unused_addr_s = ^{mem_if.ALUResult[31:AW+2], mem_if.ALUResult[1:0]};

  assign full_s   = (count_q == CW'(SB_DEPTH));
  assign drain_s  = (state_q == ST_DRAIN);
  assign stall_s  = reset & ((mem_if.MemWrite & full_s) |
                             (drain_s & (mem_if.MemWrite | mem_if.MemRead)));
  assign accept_s = mem_if.MemWrite & ~full_s & (state_q == ST_IDLE);
  assign retire_s = (count_q != {CW{1'b0}}) & (~mem_if.MemRead | full_s | drain_s);
  assign rd_en_s  = reset & mem_if.MemRead & ~mem_if.MemWrite & ~stall_s;

  // Occupancy and pointer bookkeeping; a simultaneous accept and retire cancel out.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({accept_s, retire_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    if (retire_s) begin
      head_d = head_q + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      head_d = head_q;
    end
    if (accept_s) begin
      tail_d = tail_q + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      tail_d = tail_q;
    end
  end

  // Flush sequencing; DONE is reached on the edge where the buffer becomes empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_if.FlushReq) begin
          state_d = (count_d == {CW{1'b0}}) ? ST_DONE : ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (count_d == {CW{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Walk from oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    logic [SW-1:0] slot_v;
    fwd_hit_s  = 1'b0;
    fwd_data_s = 32'd0;
    slot_v     = head_q;
    for (int k = 0; k < SB_DEPTH; k++) begin
      slot_v = head_q + k[SW-1:0];
      if ((CW'(k) < count_q) && (sb_idx_q[slot_v] == req_idx_s)) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = sb_data_q[slot_v];
      end else begin
        fwd_hit_s  = fwd_hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  // Load data path.
  always_comb begin
    rdata_s = 32'd0;
    if (!rd_en_s) begin
      rdata_s = 32'd0;
    end else if (fwd_hit_s) begin
      rdata_s = fwd_data_s;
    end else begin
      rdata_s = mem_q[req_idx_s];
    end
  end

  assign mem_if.ReadData  = rdata_s;
  assign mem_if.MemStall  = stall_s;
  assign mem_if.FlushDone = reset & (state_q == ST_DONE);

  // Control state; reset discards buffered stores and any drain in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= {CW{1'b0}};
      head_q  <= {SW{1'b0}};
      tail_q  <= {SW{1'b0}};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Buffer payload and RAM carry no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      sb_idx_q[tail_q]  <= req_idx_s;
      sb_data_q[tail_q] <= mem_if.WriteData;
    end
    if (retire_s) begin
      mem_q[sb_idx_q[head_q]] <= sb_data_q[head_q];
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboarded bench for data_mem_responder: each driven cycle queues its hand-derived expected
// outputs, which are popped and compared at the following falling edge.
module tb_data_mem_responder;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        stall;
    logic        done;
  } exp_t;

  exp_t exp_q[$];

  data_mem_responder_if bus ();

  data_mem_responder #(.MEM_WORDS(64), .SB_DEPTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .mem_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic we, input logic re, input logic [31:0] addr,
                      input logic [31:0] wd, input logic fl, input logic [31:0] erd,
                      input logic est, input logic edn, input string tag);
    exp_t e;
    exp_t o;
    bus.MemWrite  = we;
    bus.MemRead   = re;
    bus.ALUResult = addr;
    bus.WriteData = wd;
    bus.FlushReq  = fl;
    e.tag   = tag;
    e.rd    = erd;
    e.stall = est;
    e.done  = edn;
    exp_q.push_back(e);
    @(negedge clk);
    o = exp_q.pop_front();
    check_eq({o.tag, ".rd"}, bus.ReadData, o.rd);
    check_eq({o.tag, ".stall"}, {31'd0, bus.MemStall}, {31'd0, o.stall});
    check_eq({o.tag, ".done"}, {31'd0, bus.FlushDone}, {31'd0, o.done});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.ALUResult = 32'd0;
    bus.WriteData = 32'd0;
    bus.FlushReq  = 1'b0;

    // Outputs held low while in reset, even with requests present.
    step(1'b0, 1'b1, 32'h10, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, "rst_rd");
    step(1'b1, 1'b1, 32'h10, 32'h5, 1'b0, 32'd0, 1'b0, 1'b0, "rst_wr");
    reset = 1'b1;

    // Seed RAM with known words.
    step(1'b1, 1'b0, 32'h30, 32'hAAAA0030, 1'b0, 32'd0, 1'b0, 1'b0, "seed0");
    step(1'b1, 1'b0, 32'h34, 32'hBBBB0034, 1'b0, 32'd0, 1'b0, 1'b0, "seed1");
    step(1'b1, 1'b0, 32'h40, 32'h40404040, 1'b0, 32'd0, 1'b0, 1'b0, "seed2");
    step(1'b0, 1'b0, 32'h0,  32'd0,        1'b0, 32'd0, 1'b0, 1'b0, "seed_idle");
    step(1'b0, 1'b1, 32'h30, 32'd0, 1'b0, 32'hAAAA0030, 1'b0, 1'b0, "ram30");
    step(1'b0, 1'b1, 32'h34, 32'd0, 1'b0, 32'hBBBB0034, 1'b0, 1'b0, "ram34");
    step(1'b0, 1'b1, 32'h40, 32'd0, 1'b0, 32'h40404040, 1'b0, 1'b0, "ram40");

    // Store-to-load forwarding next cycle.
    step(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0, 1'b0, "fwd_st");
    step(1'b0, 1'b1, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, "fwd_ld");
    step(1'b0, 1'b0, 32'h0,  32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "fwd_idle");
    step(1'b0, 1'b1, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, "fwd_ram");

    // Youngest match wins under continuous loads.
    step(1'b1, 1'b1, 32'h20, 32'h1, 1'b0, 32'd0, 1'b0, 1'b0, "ym_st1");
    step(1'b0, 1'b1, 32'h40, 32'd0, 1'b0, 32'h40404040, 1'b0, 1'b0, "ym_ld40a");
    step(1'b1, 1'b1, 32'h20, 32'h2, 1'b0, 32'd0, 1'b0, 1'b0, "ym_st2");
    step(1'b0, 1'b1, 32'h20, 32'd0, 1'b0, 32'h2, 1'b0, 1'b0, "ym_ld20");
    step(1'b0, 1'b1, 32'h40, 32'd0, 1'b0, 32'h40404040, 1'b0, 1'b0, "ym_ld40b");
    step(1'b0, 1'b0, 32'h0,  32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "ym_idle1");
    step(1'b0, 1'b0, 32'h0,  32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "ym_idle2");
    step(1'b0, 1'b1, 32'h20, 32'd0, 1'b0, 32'h2, 1'b0, 1'b0, "ym_ram");

    // Full buffer under continuous loads.
    step(1'b1, 1'b1, 32'h60, 32'hD1, 1'b0, 32'd0, 1'b0, 1'b0, "full_st1");
    step(1'b1, 1'b1, 32'h64, 32'hD2, 1'b0, 32'd0, 1'b0, 1'b0, "full_st2");
    step(1'b1, 1'b1, 32'h68, 32'hD3, 1'b0, 32'd0, 1'b0, 1'b0, "full_st3");
    step(1'b1, 1'b1, 32'h6C, 32'hD4, 1'b0, 32'd0, 1'b0, 1'b0, "full_st4");
    step(1'b1, 1'b1, 32'h70, 32'hD5, 1'b0, 32'd0, 1'b1, 1'b0, "full_st5_stall");
    step(1'b1, 1'b1, 32'h70, 32'hD5, 1'b0, 32'd0, 1'b0, 1'b0, "full_st5_acc");
    step(1'b1, 1'b1, 32'h74, 32'hD6, 1'b0, 32'd0, 1'b1, 1'b0, "full_st6_stall");
    step(1'b1, 1'b1, 32'h74, 32'hD6, 1'b0, 32'd0, 1'b0, 1'b0, "full_st6_acc");
    step(1'b0, 1'b1, 32'h60, 32'd0, 1'b0, 32'hD1, 1'b0, 1'b0, "full_ld60");
    step(1'b0, 1'b1, 32'h70, 32'd0, 1'b0, 32'hD5, 1'b0, 1'b0, "full_ld70");

    // Flush with three entries pending (0x6C, 0x70, 0x74).
    step(1'b0, 1'b1, 32'h6C, 32'd0, 1'b1, 32'hD4, 1'b0, 1'b0, "fl_req");
    step(1'b0, 1'b1, 32'h6C, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, "fl_drain1_ld");
    step(1'b0, 1'b0, 32'h0,  32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "fl_drain2");
    step(1'b1, 1'b0, 32'h80, 32'h99, 1'b0, 32'd0, 1'b1, 1'b0, "fl_drain3_st");
    step(1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 32'd0, 1'b0, 1'b1, "fl_done");
    step(1'b0, 1'b0, 32'h0,  32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "fl_after");
    step(1'b0, 1'b1, 32'h74, 32'd0, 1'b0, 32'hD6, 1'b0, 1'b0, "fl_ram74");
    step(1'b0, 1'b1, 32'h6C, 32'd0, 1'b0, 32'hD4, 1'b0, 1'b0, "fl_ram6c");

    // Flush with an empty buffer.
    step(1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, "efl_req");
    step(1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, "efl_done");
    step(1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "efl_after");

    // Reset in the middle of a drain with two entries pending.
    step(1'b1, 1'b1, 32'h30, 32'h11111111, 1'b0, 32'd0, 1'b0, 1'b0, "rd_st1");
    step(1'b1, 1'b1, 32'h34, 32'h22222222, 1'b0, 32'd0, 1'b0, 1'b0, "rd_st2");
    step(1'b0, 1'b1, 32'h30, 32'd0, 1'b1, 32'h11111111, 1'b0, 1'b0, "rd_req");
    reset = 1'b0;
    step(1'b0, 1'b1, 32'h30, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "rd_inrst");
    reset = 1'b1;
    step(1'b0, 1'b0, 32'h0,  32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "rd_idle");
    step(1'b0, 1'b1, 32'h30, 32'd0, 1'b0, 32'hAAAA0030, 1'b0, 1'b0, "rd_ram30");
    step(1'b0, 1'b1, 32'h34, 32'd0, 1'b0, 32'hBBBB0034, 1'b0, 1'b0, "rd_ram34");
    step(1'b1, 1'b1, 32'h50, 32'h5, 1'b0, 32'd0, 1'b0, 1'b0, "rd_st_ok");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, meaning the number of 32-bit words in the internal data RAM (power of 2).
REQ-002 SHALL have parameter SB_DEPTH, default 4, meaning the number of store-buffer entries (power of 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port MemWrite, input, 1, store request from the pipeline's M stage.
REQ-006 SHALL have port MemRead, input, 1, load request from the pipeline's M stage.
REQ-007 SHALL have port ALUResult, input, 32, byte address; the word index SHALL be ALUResult[log2(MEM_WORDS)+1:2]; all other bits SHALL be ignored.
REQ-008 SHALL have port WriteData, input, 32, store data.
REQ-009 SHALL have port ReadData, output, 32, load data.
REQ-010 SHALL have port MemStall, output, 1, asserted to the hazard unit when the current request cannot complete this cycle.
REQ-011 SHALL have port FlushReq, input, 1, single-cycle request to drain the store buffer into RAM.
REQ-012 SHALL have port FlushDone, output, 1, one-cycle pulse when a requested drain completes.

Function
REQ-013 SHALL hold stores in a FIFO store buffer of SB_DEPTH entries (word index, data), with a count of 0..SB_DEPTH and wrap-around head/tail pointers.
REQ-014 SHALL accept a store at the rising edge when MemWrite=1, the buffer is not full, and the state is IDLE; acceptance SHALL be zero-stall.
REQ-015 SHALL drive MemStall=1 combinationally when MemWrite=1 and count==SB_DEPTH, or when the state is DRAIN and MemWrite|MemRead=1; otherwise MemStall SHALL be 0.
REQ-016 SHALL retire the oldest entry into RAM at a rising edge when count>0 and any of these holds: MemRead=0, count==SB_DEPTH, or the state is DRAIN.
REQ-017 SHALL leave count unchanged when a store is accepted and an entry is retired at the same edge.
REQ-018 SHALL drive ReadData combinationally when MemRead=1, MemWrite=0 and MemStall=0: from the youngest buffer entry whose word index matches, otherwise from RAM.
REQ-019 SHALL drive ReadData=0 when MemRead=0, MemWrite=1 or MemStall=1.
REQ-020 SHALL treat MemWrite=1 with MemRead=1 as a store only.
REQ-021 SHALL implement a state machine with states IDLE, DRAIN and DONE.
REQ-022 SHALL transition from IDLE to DRAIN on FlushReq=1; if count==0, IDLE SHALL go directly to DONE.
REQ-023 SHALL transition from DRAIN to DONE at the edge that retires the last entry (count 1 -> 0).
REQ-024 SHALL remain in DONE for exactly one cycle with FlushDone=1, then return to IDLE.
REQ-025 SHALL ignore FlushReq while in DRAIN or DONE.
REQ-026 SHALL accept no stores while in DRAIN.
REQ-027 SHALL never assert FlushDone outside DONE.

Reset
REQ-028 SHALL, while reset=0, force state IDLE, count 0, head/tail pointers 0, MemStall 0, FlushDone 0 and ReadData 0, independent of clk.
REQ-029 SHALL discard any buffered stores and any in-progress drain on reset; RAM contents SHALL NOT be reset.
REQ-030 SHALL resume normal operation at the first rising edge after reset returns to 1.

Verification
REQ-031 SHALL cover store-to-load forwarding: store 0xDEADBEEF to 0x10, then a load from 0x10 in the next cycle -> ReadData=0xDEADBEEF and MemStall=0.
REQ-032 SHALL cover youngest-match forwarding: store 0x1 then 0x2 to 0x20 with continuous loads from 0x40 -> a load from 0x20 returns 0x2.
REQ-033 SHALL cover a full buffer under continuous loads: 4 stores, then a 5th store -> MemStall=1 for one cycle, the 5th store is accepted the following cycle, and count stays 4.
REQ-034 SHALL cover flush: 3 buffered stores, then FlushReq -> DRAIN for 3 cycles, then FlushDone=1 for one cycle; a load issued during DRAIN sees MemStall=1.
REQ-035 SHALL cover flush on an empty buffer: FlushReq with count 0 -> FlushDone=1 on the next cycle.
REQ-036 SHALL cover reset mid-drain: reset=0 in DRAIN with 2 entries pending -> FlushDone is never asserted, count=0, and a later load from those addresses returns the prior RAM contents.
